// File: rtl/acc_norm_pkg.sv
// Shared definitions for the quire normaliser: derived widths, segment
// addressing and the per-word outcome classification.
package acc_norm_pkg;

    // Classification of one normalised word, in priority order.
    typedef enum logic [1:0] {
        NORM = 2'd0,
        OVF  = 2'd1,
        UDF  = 2'd2,
        ZERO = 2'd3
    } outcome_e;

    // Total accumulator width: head segment plus all body segments.
    function automatic int calc_aw(input int acc_head, input int nseg, input int segw);
        return acc_head + nseg * segw;
    endfunction

    // Number of fraction bits below the binary point.
    function automatic int calc_fb(input int fseg, input int segw);
        return fseg * segw;
    endfunction

    // Signed scale-factor width able to hold any lead position minus FB.
    function automatic int calc_sfw(input int aw);
        return $clog2(aw) + 1;
    endfunction

    // Bit index of the LSB of segment idx (the head segment is idx = NSEG).
    function automatic int seg_base(input int idx, input int segw);
        return idx * segw;
    endfunction

endpackage

// File: rtl/acc_seg_lzd.sv
// Leading-zero counter for one accumulator segment, with an all-zero flag.
// An all-zero input reports lzc = W.
module acc_seg_lzd
    import acc_norm_pkg::*;
#(
    parameter  int W  = 24,
    localparam int LW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [LW-1:0] lzc,
    output logic          zero
);

    // Scan upward so the highest set bit wins the final assignment.
    always_comb begin
        lzc  = LW'(W);
        zero = ~|din;
        for (int i = 0; i < W; i++) begin
            if (din[i]) lzc = LW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/acc_norm_pipe.sv
// Quire normaliser: converts a segmented two's-complement accumulator into
// sign, scale factor and a leading-one-aligned mantissa with guard/sticky.
// Three pipeline stages:
//   S1 sign/magnitude and per-segment nonzero flags
//   S2 top-segment select and leading-one position
//   S3 scale classification and mantissa extraction (output registers)
//
// Handshake: a word moves across a stage boundary on a clock edge where the
// sender's valid and the receiver's ready are both high. Once valid is high
// the sender holds its data unchanged until accepted. A stage is ready when
// it is empty or its own content is leaving in the same cycle, so ready is
// purely combinational from stage valids and out_rdy, and a full pipeline
// streams one word per cycle with no bubble after a stall.
module acc_norm_pipe
    import acc_norm_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int EXP      = 2,
    parameter  int K        = 9,
    parameter  int NSEG     = 4,
    parameter  int FSEG     = 2,
    parameter  int SEGW     = (2 ** EXP) * (WIDTH - 2),
    parameter  int ACC_HEAD = $clog2(K) + 2,
    parameter  int MTS      = WIDTH - 3 - EXP,
    parameter  int MW       = 2 * MTS + 2,
    parameter  int SF_MAX   = SEGW - 1,
    parameter  int SF_MIN   = -SEGW,
    localparam int AW       = calc_aw(ACC_HEAD, NSEG, SEGW),
    localparam int FB       = calc_fb(FSEG, SEGW),
    localparam int SFW      = calc_sfw(AW)
) (
    input  logic                  clk_i,
    input  logic                  rstn,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [AW-1:0]         acc_i,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic                  sign_q,
    output logic signed [SFW-1:0] sf_q,
    output logic [MW-1:0]         mts_q,
    output logic                  grd_q,
    output logic                  stk_q,
    output logic                  ovf,
    output logic                  udf,
    output logic                  nzero
);

    localparam int PW = $clog2(AW);
    localparam int TW = $clog2(NSEG + 1);
    localparam int LW = $clog2(SEGW + 1);

    // Stage advance enables
    logic adv1, adv2, adv3;

    // Stage 1 state
    logic            s1_vld;
    logic            s1_sign;
    logic [AW-1:0]   s1_mag;
    logic [NSEG:0]   s1_nz;

    // Stage 2 state
    logic            s2_vld;
    logic            s2_sign;
    logic [AW-1:0]   s2_mag;
    logic [PW-1:0]   s2_p;
    logic            s2_zero;

    // Combinational intermediates
    logic [AW-1:0]    mag_c;
    logic [NSEG:0]    nz_c;
    logic [TW-1:0]    top_c;
    logic [SEGW-1:0]  seg_c;
    logic [LW-1:0]    lzc;
    logic             seg_zero;
    logic [PW-1:0]    p_c;
    logic signed [SFW:0] sf_c;
    logic [PW-1:0]    sh_c;
    logic [AW-1:0]    shl_c;
    outcome_e         oc_c;

    // Backpressure chain: each stage may load when it is empty or draining.
    always_comb begin
        adv3   = ~out_vld | out_rdy;
        adv2   = ~s2_vld | adv3;
        adv1   = ~s1_vld | adv2;
        in_rdy = adv1;
    end

    // S1: magnitude (mod 2^AW, so the most-negative word keeps its MSB) and
    // nonzero flags per segment, head segment at index NSEG.
    always_comb begin
        mag_c = acc_i[AW-1] ? -acc_i : acc_i;
        nz_c  = '0;
        for (int i = 0; i < NSEG; i++) begin
            nz_c[i] = |mag_c[i*SEGW +: SEGW];
        end
        nz_c[NSEG] = |mag_c[AW-1 -: ACC_HEAD];
    end

    // S1 register
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            s1_vld  <= 1'b0;
            s1_sign <= 1'b0;
            s1_mag  <= '0;
            s1_nz   <= '0;
        end else if (adv1) begin
            s1_vld <= in_vld;
            if (in_vld) begin
                s1_sign <= acc_i[AW-1];
                s1_mag  <= mag_c;
                s1_nz   <= nz_c;
            end
        end
    end

    // S2: pick the highest nonzero segment; head is zero-extended so the
    // same base + SEGW-1-lzc formula applies to every segment.
    always_comb begin
        top_c = '0;
        for (int i = 0; i <= NSEG; i++) begin
            if (s1_nz[i]) top_c = TW'(i);
        end
        seg_c = '0;
        for (int i = 0; i < NSEG; i++) begin
            if (top_c == TW'(i)) seg_c = s1_mag[i*SEGW +: SEGW];
        end
        if (top_c == TW'(NSEG)) seg_c = SEGW'(s1_mag[AW-1 -: ACC_HEAD]);
    end

    acc_seg_lzd #(
        .W (SEGW)
    ) u_lzd (
        .din  (seg_c),
        .lzc  (lzc),
        .zero (seg_zero)
    );

    // Lead position; meaningless (and unused) when the word is zero.
    always_comb begin
        p_c = PW'(seg_base(int'(top_c), SEGW) + SEGW - 1 - int'(lzc));
    end

    // S2 register. With no nonzero segment the mux falls back to segment 0,
    // which is then all-zero, so seg_zero is exactly nz == 0.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            s2_vld  <= 1'b0;
            s2_sign <= 1'b0;
            s2_mag  <= '0;
            s2_p    <= '0;
            s2_zero <= 1'b0;
        end else if (adv2) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_sign <= s1_sign;
                s2_mag  <= s1_mag;
                s2_p    <= p_c;
                s2_zero <= seg_zero;
            end
        end
    end

    // S3: classify the scale and left-align the leading one at the MSB so the
    // mantissa, guard and sticky are fixed slices of the shifted magnitude.
    always_comb begin
        sf_c  = $signed((SFW+1)'(s2_p)) - $signed((SFW+1)'(FB));
        sh_c  = PW'(AW - 1) - s2_p;
        shl_c = s2_mag << sh_c;
        if (s2_zero)
            oc_c = ZERO;
        else if (sf_c > $signed((SFW+1)'(SF_MAX)))
            oc_c = OVF;
        else if (sf_c < $signed((SFW+1)'(SF_MIN)))
            oc_c = UDF;
        else
            oc_c = NORM;
    end

    // S3 / output register: holds while stalled.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            out_vld <= 1'b0;
            sign_q  <= 1'b0;
            sf_q    <= '0;
            mts_q   <= '0;
            grd_q   <= 1'b0;
            stk_q   <= 1'b0;
            ovf     <= 1'b0;
            udf     <= 1'b0;
            nzero   <= 1'b1;
        end else if (adv3) begin
            out_vld <= s2_vld;
            if (s2_vld) begin
                sign_q <= s2_sign;
                ovf    <= (oc_c == OVF);
                udf    <= (oc_c == UDF) || (oc_c == ZERO);
                nzero  <= (oc_c != ZERO);
                if (oc_c == NORM) begin
                    sf_q  <= sf_c[SFW-1:0];
                    mts_q <= shl_c[AW-1 -: MW];
                    grd_q <= shl_c[AW-1-MW];
                    stk_q <= |shl_c[AW-2-MW:0];
                end else begin
                    sf_q  <= '0;
                    mts_q <= '0;
                    grd_q <= 1'b0;
                    stk_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_norm_pipe.sv
// Directed bench for acc_norm_pipe at default parameters
// (AW=102, FB=48, SFW=8, MW=8).
module tb_acc_norm_pipe;

    localparam int AW  = 102;
    localparam int SFW = 8;
    localparam int MW  = 8;

    // ---------------- clock / reset ----------------
    logic                  clk_i   = 1'b0;
    logic                  rstn    = 1'b0;
    logic                  in_vld  = 1'b0;
    logic                  in_rdy;
    logic [AW-1:0]         acc_i   = '0;
    logic                  out_vld;
    logic                  out_rdy = 1'b1;
    logic                  sign_q;
    logic signed [SFW-1:0] sf_q;
    logic [MW-1:0]         mts_q;
    logic                  grd_q;
    logic                  stk_q;
    logic                  ovf;
    logic                  udf;
    logic                  nzero;

    always #5 clk_i = ~clk_i;

    acc_norm_pipe dut (
        .clk_i   (clk_i),
        .rstn    (rstn),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .acc_i   (acc_i),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .sign_q  (sign_q),
        .sf_q    (sf_q),
        .mts_q   (mts_q),
        .grd_q   (grd_q),
        .stk_q   (stk_q),
        .ovf     (ovf),
        .udf     (udf),
        .nzero   (nzero)
    );

    // ---------------- bookkeeping ----------------
    int n_chk   = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int acc_cnt = 0;
    bit lat_chk = 1'b1;

    logic [21:0] exp_q[$];
    int          lat_q[$];

    logic [21:0] obs_w;
    assign obs_w = {sign_q, sf_q, mts_q, grd_q, stk_q, ovf, udf, nzero};

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (rstn && in_vld && in_rdy) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Expected result word: {sign, sf, mts, grd, stk, ovf, udf, nzero}
    function automatic logic [21:0] mk(input logic s, input logic [7:0] sf, input logic [7:0] m,
                                       input logic g, input logic st, input logic o,
                                       input logic u, input logic nz);
        return {s, sf, m, g, st, o, u, nz};
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge; returns at a negedge with in_vld low.
    task automatic send(input logic [AW-1:0] v, input logic [21:0] e);
        int n;
        n      = 0;
        in_vld = 1'b1;
        acc_i  = v;
        @(posedge clk_i);
        while (!in_rdy && n < 50) begin
            @(posedge clk_i);
            n++;
        end
        if (n >= 50) chk("in_rdy_timeout", 64'(1), 64'(0));
        exp_q.push_back(e);
        lat_q.push_back(cyc);
        @(negedge clk_i);
        in_vld = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk_i) begin
        logic [21:0] e;
        int          a;
        if (rstn && out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                a = lat_q.pop_front();
                chk("result", 64'(obs_w), 64'(e));
                if (lat_chk) chk("latency", 64'(cyc - a), 64'(3));
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [22:0] snap;
    int          base;
    int          seen;

    initial begin
        // Reset values while rstn is held low
        repeat (2) @(negedge clk_i);
        chk("rst_out_vld", 64'(out_vld), 64'(0));
        chk("rst_in_rdy", 64'(in_rdy), 64'(1));
        chk("rst_outputs", 64'(obs_w), 64'(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 1)));
        rstn = 1'b1;
        @(negedge clk_i);

        // Directed vectors, back-to-back with out_rdy high
        send(AW'(1) << 48,                      mk(0, 8'h00, 8'h80, 0, 0, 0, 0, 1));
        send(-(AW'(3) << 48),                   mk(1, 8'h01, 8'hC0, 0, 0, 0, 0, 1));
        send(AW'(1) << 71,                      mk(0, 8'd23, 8'h80, 0, 0, 0, 0, 1));
        send(AW'(1) << 72,                      mk(0, 8'h00, 8'h00, 0, 0, 1, 0, 1));
        send(AW'(1) << 24,                      mk(0, 8'hE8, 8'h80, 0, 0, 0, 0, 1));
        send(AW'(1) << 23,                      mk(0, 8'h00, 8'h00, 0, 0, 0, 1, 1));
        send(AW'(1) << 96,                      mk(0, 8'h00, 8'h00, 0, 0, 1, 0, 1));
        send(AW'(0),                            mk(0, 8'h00, 8'h00, 0, 0, 0, 1, 0));
        send(AW'(1) << 101,                     mk(1, 8'h00, 8'h00, 0, 0, 1, 0, 1));
        send((AW'(1) << 48) | (AW'(1) << 40) | (AW'(1) << 38),
                                                mk(0, 8'h00, 8'h80, 1, 1, 0, 0, 1));
        send((AW'(1) << 48) | (AW'(1) << 40),   mk(0, 8'h00, 8'h80, 1, 0, 0, 0, 1));
        send(AW'(8'hAB) << 40,                  mk(0, 8'hFF, 8'hAB, 0, 0, 0, 0, 1));
        send(-AW'(1),                           mk(1, 8'h00, 8'h00, 0, 0, 0, 1, 1));
        send(-((AW'(1) << 48) + AW'(1)),        mk(1, 8'h00, 8'h80, 0, 1, 0, 0, 1));
        send((AW'(1) << 71) | (AW'(3) << 62),   mk(0, 8'd23, 8'h80, 1, 1, 0, 0, 1));
        send(-(AW'(1) << 96),                   mk(1, 8'h00, 8'h00, 0, 0, 1, 0, 1));
        send(AW'(9'h1FF) << 24,                 mk(0, 8'hF0, 8'hFF, 1, 0, 0, 0, 1));
        drain();

        // Backpressure: 5 words, out_rdy low for 6 cycles
        lat_chk = 1'b0;
        out_rdy = 1'b0;
        base    = acc_cnt;
        fork
            begin
                send(AW'(1) << 48,                    mk(0, 8'h00, 8'h80, 0, 0, 0, 0, 1));
                send(-(AW'(3) << 48),                 mk(1, 8'h01, 8'hC0, 0, 0, 0, 0, 1));
                send(AW'(1) << 71,                    mk(0, 8'd23, 8'h80, 0, 0, 0, 0, 1));
                send(AW'(8'hAB) << 40,                mk(0, 8'hFF, 8'hAB, 0, 0, 0, 0, 1));
                send((AW'(1) << 48) | (AW'(1) << 40), mk(0, 8'h00, 8'h80, 1, 0, 0, 0, 1));
            end
            begin
                repeat (3) @(negedge clk_i);
                chk("bp_in_rdy_low", 64'(in_rdy), 64'(0));
                chk("bp_accepted3", 64'(acc_cnt - base), 64'(3));
                chk("bp_out_vld", 64'(out_vld), 64'(1));
                snap = {out_vld, obs_w};
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk_i);
                    chk("bp_hold", 64'({out_vld, obs_w}), 64'(snap));
                end
                @(posedge clk_i);
                #1 out_rdy = 1'b1;
            end
        join
        drain();
        chk("bp_accepted5", 64'(acc_cnt - base), 64'(5));
        lat_chk = 1'b1;

        // Reset mid-stream: fill the pipe with out_rdy low, then reset
        @(negedge clk_i);
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        acc_i   = AW'(1) << 48;
        repeat (3) @(negedge clk_i);
        in_vld = 1'b0;
        chk("pre_rst_vld", 64'(out_vld), 64'(1));
        rstn = 1'b0;
        @(posedge clk_i);
        #1;
        chk("mid_rst_vld", 64'(out_vld), 64'(0));
        chk("mid_rst_in_rdy", 64'(in_rdy), 64'(1));
        chk("mid_rst_outputs", 64'(obs_w), 64'(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 1)));
        @(negedge clk_i);
        out_rdy = 1'b1;
        rstn    = 1'b1;
        seen    = 0;
        repeat (6) begin
            @(negedge clk_i);
            seen += int'(out_vld);
        end
        chk("no_out_after_rst", 64'(seen), 64'(0));

        // Pipeline still works after reset
        send(AW'(1) << 48, mk(0, 8'h00, 8'h80, 0, 0, 0, 0, 1));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

endmodule
